// File: rtl/per2axi_pkg.sv
// ---------------------------------------------------------------------------
// per2axi_pkg: shared AXI R-channel encodings, beat struct and arbiter states.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package per2axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int unsigned AXI_ID_WIDTH   = 4;
   localparam int unsigned AXI_DATA_WIDTH = 64;
   localparam int unsigned AXI_USER_WIDTH = 6;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [1:0]                resp;
      logic [AXI_USER_WIDTH-1:0] user;
      logic                      last;
   } r_beat_t;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/per2axi_rr_pick.sv
// ---------------------------------------------------------------------------
// per2axi_rr_pick: combinational round-robin pick, first request at/after ptr.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module per2axi_rr_pick #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   // Two ascending passes: indices at/above the pointer first, then the wrap.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int unsigned j = 0; j < N; j++) begin
         if (!valid_o && (j >= 32'(ptr_i)) && req_i[j]) begin
            valid_o  = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IDX_W'(j);
         end
      end
      for (int unsigned j = 0; j < N; j++) begin
         if (!valid_o && (j < 32'(ptr_i)) && req_i[j]) begin
            valid_o  = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IDX_W'(j);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/per2axi_r_arbiter.sv
// ---------------------------------------------------------------------------
// per2axi_r_arbiter: round-robin R-channel arbiter with registered output.
// Burst locking enabled by PER2AXI_R_ARB_BURST_LOCK_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module per2axi_r_arbiter
   import per2axi_pkg::*;
#(
   parameter int unsigned N_SLAVES   = 2,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned USER_WIDTH = 6
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [N_SLAVES-1:0]                  slave_valid_i,
   input  logic [N_SLAVES-1:0][DATA_WIDTH-1:0]  slave_data_i,
   input  logic [N_SLAVES-1:0][1:0]             slave_resp_i,
   input  logic [N_SLAVES-1:0][USER_WIDTH-1:0]  slave_user_i,
   input  logic [N_SLAVES-1:0][ID_WIDTH-1:0]    slave_id_i,
   input  logic [N_SLAVES-1:0]                  slave_last_i,
   output logic [N_SLAVES-1:0]                  slave_ready_o,
   output logic                                 master_valid_o,
   output logic [DATA_WIDTH-1:0]                master_data_o,
   output logic [1:0]                           master_resp_o,
   output logic [USER_WIDTH-1:0]                master_user_o,
   output logic [ID_WIDTH-1:0]                  master_id_o,
   output logic                                 master_last_o,
   input  logic                                 master_ready_i
);

   localparam int unsigned      IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLAVES - 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
   logic             valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [1:0]            resp_q, resp_d;
   logic [USER_WIDTH-1:0] user_q, user_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic                  last_q, last_d;

   logic                slot_free;
   logic [N_SLAVES-1:0] pick_gnt;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_valid;
   logic [IDX_W-1:0]    sel_idx;
   logic                sel_ok;
   logic                accept;

   assign slot_free = !valid_q || master_ready_i;

   per2axi_rr_pick #(
      .N     (N_SLAVES),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i   (slave_valid_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      lock_idx_d    = lock_idx_q;
      valid_d       = valid_q;
      data_d        = data_q;
      resp_d        = resp_q;
      user_d        = user_q;
      id_d          = id_q;
      last_d        = last_q;
      sel_idx       = pick_idx;
      sel_ok        = pick_valid;
      slave_ready_o = '0;

      if (state_q == ARB_LOCKED) begin
         sel_idx                   = lock_idx_q;
         sel_ok                    = slave_valid_i[lock_idx_q];
         slave_ready_o[lock_idx_q] = slot_free;
      end else begin
         slave_ready_o = pick_gnt & {N_SLAVES{slot_free}};
      end

      // Readys stay low for the whole time reset is held.
      if (rst_i) begin
         slave_ready_o = '0;
      end
      accept = sel_ok && slot_free && !rst_i;

      if (accept) begin
         valid_d = 1'b1;
         data_d  = slave_data_i[sel_idx];
         resp_d  = slave_resp_i[sel_idx];
         user_d  = slave_user_i[sel_idx];
         id_d    = slave_id_i[sel_idx];
         last_d  = slave_last_i[sel_idx];
`ifdef PER2AXI_R_ARB_BURST_LOCK_EN
         if (slave_last_i[sel_idx]) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
         end else begin
            state_d    = ARB_LOCKED;
            lock_idx_d = sel_idx;
         end
`else
         rr_ptr_d = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
`endif
      end else if (master_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ARB_IDLE;
         rr_ptr_q   <= '0;
         lock_idx_q <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         resp_q     <= RESP_OKAY;
         user_q     <= '0;
         id_q       <= '0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         resp_q     <= resp_d;
         user_q     <= user_d;
         id_q       <= id_d;
         last_q     <= last_d;
      end
   end

   assign master_valid_o = valid_q;
   assign master_data_o  = data_q;
   assign master_resp_o  = resp_q;
   assign master_user_o  = user_q;
   assign master_id_o    = id_q;
   assign master_last_o  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_per2axi_r_arbiter.sv
// ---------------------------------------------------------------------------
// tb_per2axi_r_arbiter: per-source beat queues driving the arbiter, checked
// every cycle against a queue-level model of the grant/lock rules.
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_per2axi_r_arbiter;

   localparam int N  = 3;
   localparam int IW = 4;
   localparam int DW = 64;
   localparam int UW = 6;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic [UW-1:0] user;
      logic [IW-1:0] id;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0]          s_valid;
   logic [N-1:0][DW-1:0]  s_data;
   logic [N-1:0][1:0]     s_resp;
   logic [N-1:0][UW-1:0]  s_user;
   logic [N-1:0][IW-1:0]  s_id;
   logic [N-1:0]          s_last;
   logic [N-1:0]          s_ready;
   logic                  m_valid;
   logic [DW-1:0]         m_data;
   logic [1:0]            m_resp;
   logic [UW-1:0]         m_user;
   logic [IW-1:0]         m_id;
   logic                  m_last;
   logic                  m_ready;

   per2axi_r_arbiter #(
      .N_SLAVES   (N),
      .ID_WIDTH   (IW),
      .DATA_WIDTH (DW),
      .USER_WIDTH (UW)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .slave_valid_i  (s_valid),
      .slave_data_i   (s_data),
      .slave_resp_i   (s_resp),
      .slave_user_i   (s_user),
      .slave_id_i     (s_id),
      .slave_last_i   (s_last),
      .slave_ready_o  (s_ready),
      .master_valid_o (m_valid),
      .master_data_o  (m_data),
      .master_resp_o  (m_resp),
      .master_user_o  (m_user),
      .master_id_o    (m_id),
      .master_last_o  (m_last),
      .master_ready_i (m_ready)
   );

   always #5 clk = ~clk;

   beat_t         srcq [N][$];
   logic [DW-1:0] consumed[$];
   logic [DW-1:0] exp_seq[$];
   int checks = 0;
   int errors = 0;

   // Model state: who owns the channel, where rotation resumes, what sits in the register.
   bit     m_locked;
   int     m_owner;
   int     m_rr;
   bit     m_mv;
   beat_t  m_reg;
   bit [N-1:0] act, prev_v, acc_v;
   bit     rnd_valid, rnd_ready;
   int     stall_cnt;
   int     pushed;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, a, e);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_owner = 0; m_rr = 0; m_mv = 0; m_reg = '0;
      act = '0; prev_v = '0; acc_v = '0;
   endtask

   task automatic push_beat(input int k, input logic [DW-1:0] d, input bit last);
      beat_t b;
      b.data = d;
      b.resp = 2'($urandom_range(0, 3));
      b.user = UW'($urandom_range(0, 63));
      b.id   = IW'(k + 1);
      b.last = last;
      srcq[k].push_back(b);
      pushed++;
   endtask

   task automatic push_burst(input int k, input logic [DW-1:0] base, input int len);
      for (int b = 0; b < len; b++) push_beat(k, base + DW'(b), b == len - 1);
   endtask

   function automatic bit pending();
      bit p = m_mv;
      for (int k = 0; k < N; k++) if (srcq[k].size() > 0) p = 1;
      return p;
   endfunction

   // One clock: drive, compare against the model, advance the model. Entered at posedge+1.
   task automatic step();
      logic [N-1:0] exp_rdy;
      bit free, acc;
      int g;
      for (int k = 0; k < N; k++) begin
         if (!rnd_valid) act[k] = 1'b1;
         else if (!prev_v[k] || acc_v[k]) act[k] = 1'($urandom_range(0, 1));
         s_valid[k] = act[k] && (srcq[k].size() > 0);
         if (srcq[k].size() > 0) begin
            s_data[k] = srcq[k][0].data; s_resp[k] = srcq[k][0].resp;
            s_user[k] = srcq[k][0].user; s_id[k]   = srcq[k][0].id;
            s_last[k] = srcq[k][0].last;
         end else begin
            s_data[k] = '0; s_resp[k] = '0; s_user[k] = '0; s_id[k] = '0; s_last[k] = 1'b0;
         end
      end
      if (stall_cnt > 0) begin m_ready = 1'b0; stall_cnt--; end
      else if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
      else m_ready = 1'b1;
      #1;
      free = !m_mv || m_ready;
      g = -1;
      if (m_locked) g = m_owner;
      else for (int o = 0; o < N; o++) if (g < 0 && s_valid[(m_rr + o) % N]) g = (m_rr + o) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = free;
      acc = (g >= 0) && free && s_valid[g];
      chk("slave_ready", 64'(s_ready), 64'(exp_rdy));
      chk("m_valid", 64'(m_valid), 64'(m_mv));
      chk("m_data", m_data, m_reg.data);
      chk("m_resp", 64'(m_resp), 64'(m_reg.resp));
      chk("m_user", 64'(m_user), 64'(m_reg.user));
      chk("m_id", 64'(m_id), 64'(m_reg.id));
      chk("m_last", 64'(m_last), 64'(m_reg.last));
      if (m_mv && m_ready) consumed.push_back(m_reg.data);
      prev_v = s_valid;
      acc_v  = '0;
      if (acc) begin
         m_reg = srcq[g].pop_front();
         m_mv = 1; acc_v[g] = 1'b1;
         if (m_reg.last) begin
            m_locked = 0; m_rr = (g + 1) % N;
         end else begin
`ifdef PER2AXI_R_ARB_BURST_LOCK_EN
            m_locked = 1; m_owner = g;
`else
            m_rr = (g + 1) % N;
`endif
         end
      end else if (m_ready) begin
         m_mv = 0;
      end
      @(posedge clk); #1;
   endtask

   task automatic run_all(input int budget, output int ncyc);
      ncyc = 0;
      while (pending() && ncyc < budget) begin
         step();
         ncyc++;
      end
      if (pending()) begin
         checks++; errors++;
         $display("FAIL drain_timeout actual=%0d cycles required=drained", ncyc);
      end
   endtask

   task automatic chk_seq(input string nm);
      chk({nm, "_len"}, 64'(consumed.size()), 64'(exp_seq.size()));
      for (int i = 0; i < exp_seq.size() && i < consumed.size(); i++)
         chk(nm, consumed[i], exp_seq[i]);
      consumed.delete();
      exp_seq.delete();
   endtask

   initial begin
      int n;
      rst = 1'b1; m_ready = 1'b0; pushed = 0; stall_cnt = 0;
      rnd_valid = 0; rnd_ready = 0;
      s_valid = '0; s_data = '0; s_resp = '0; s_user = '0; s_id = '0; s_last = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      s_valid = 3'b001; s_last = 3'b001; m_ready = 1'b1;
      #1;
      chk("reset_m_valid", 64'(m_valid), 64'd0);
      chk("reset_m_data", m_data, 64'd0);
      chk("reset_m_id_last", 64'({m_id, m_last, m_resp, m_user}), 64'd0);
      chk("reset_ready", 64'(s_ready), 64'd0);
      s_valid = '0; s_last = '0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Burst lock: source 1 waits until source 0's burst finishes.
      for (int i = 0; i < 4; i++) push_beat(0, 64'hA0 + 64'(i), i == 3);
      push_beat(1, 64'hB0, 1);
      run_all(50, n);
      chk("lock_cycles", 64'(n), 64'd6);
`ifdef PER2AXI_R_ARB_BURST_LOCK_EN
      exp_seq.push_back(64'hA0); exp_seq.push_back(64'hA1); exp_seq.push_back(64'hA2);
      exp_seq.push_back(64'hA3); exp_seq.push_back(64'hB0);
`else
      exp_seq.push_back(64'hA0); exp_seq.push_back(64'hB0); exp_seq.push_back(64'hA1);
      exp_seq.push_back(64'hA2); exp_seq.push_back(64'hA3);
`endif
      chk_seq("lock_order");

      // Reset mid-burst with source 1 owning a 4-beat burst after 2 beats.
      push_burst(1, 64'hD0, 4);
      step(); step();
      rst = 1'b1;
      #1;
      chk("midrst_m_valid", 64'(m_valid), 64'd0);
      chk("midrst_ready", 64'(s_ready), 64'd0);
      chk("midrst_m_data", m_data, 64'd0);
      for (int k = 0; k < N; k++) srcq[k].delete();
      s_valid = '0;
      model_reset();
      consumed.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      push_beat(2, 64'hE2, 1);
      push_beat(1, 64'hE1, 1);
      run_all(50, n);
      exp_seq.push_back(64'hE1); exp_seq.push_back(64'hE2);
      chk_seq("postrst_order");

      // Fairness: every source continuously valid with single-beat bursts.
      for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) push_beat(k, 64'h100 * (k + 1) + 64'(r), 1);
      run_all(50, n);
      chk("fair_cycles", 64'(n), 64'd7);
      exp_seq.push_back(64'h100); exp_seq.push_back(64'h200); exp_seq.push_back(64'h300);
      exp_seq.push_back(64'h101); exp_seq.push_back(64'h201); exp_seq.push_back(64'h301);
      chk_seq("fair_order");

      // Wrap: owner N-1 finishes while sources 0 and N-2 request.
      push_burst(2, 64'hC0, 2);
      step();
      push_beat(0, 64'hF0, 1);
      push_beat(1, 64'hF1, 1);
      run_all(50, n);
`ifdef PER2AXI_R_ARB_BURST_LOCK_EN
      exp_seq.push_back(64'hC0); exp_seq.push_back(64'hC1);
      exp_seq.push_back(64'hF0); exp_seq.push_back(64'hF1);
`else
      exp_seq.push_back(64'hC0); exp_seq.push_back(64'hF0);
      exp_seq.push_back(64'hF1); exp_seq.push_back(64'hC1);
`endif
      chk_seq("wrap_order");

      // Backpressure for 5 cycles mid-burst.
      push_burst(0, 64'h500, 6);
      step(); step();
      stall_cnt = 5;
      run_all(50, n);
      for (int i = 0; i < 6; i++) exp_seq.push_back(64'h500 + 64'(i));
      chk_seq("bp_order");

      // Randomized traffic.
      rnd_valid = 1; rnd_ready = 1; pushed = 0;
      for (int it = 0; it < 600; it++) begin
         for (int k = 0; k < N; k++)
            if (srcq[k].size() < 3 && $urandom_range(0, 3) == 0)
               push_burst(k, 64'(k) << 56 | 64'(it) << 8, $urandom_range(1, 4));
         step();
      end
      run_all(3000, n);
      chk("rand_count", 64'(consumed.size()), 64'(pushed));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/per2axi_r_arbiter.md
# per2axi_r_arbiter

Round-robin arbiter that shares one AXI read-response (R) channel among N_SLAVES response sources inside the per2axi bridge. It grants one source at a time and holds the grant for a whole burst until the beat marked last. Each granted beat passes through a single full-throughput output register, so beats from different bursts never interleave on the master side. It sits between the per-port read-response queues and the AXI R output of the bridge.

## Interface
- N_SLAVES, 2: number of response sources (≥2).
- ID_WIDTH, 4: AXI ID width.
- DATA_WIDTH, 64: R data width.
- USER_WIDTH, 6: R user width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- slave_valid_i  in  N_SLAVES  per-source beat valid.
- slave_data_i  in  N_SLAVES×DATA_WIDTH  per-source data (packed array).
- slave_resp_i  in  N_SLAVES×2  per-source response.
- slave_user_i  in  N_SLAVES×USER_WIDTH  per-source user.
- slave_id_i  in  N_SLAVES×ID_WIDTH  per-source ID.
- slave_last_i  in  N_SLAVES  per-source last flag.
- slave_ready_o  out  N_SLAVES  per-source ready; at most one bit high.
- master_valid_o, master_data_o, master_resp_o, master_user_o, master_id_o, master_last_o  out  1/DATA_WIDTH/2/USER_WIDTH/ID_WIDTH/1  registered R beat.
- master_ready_i  in  1  downstream ready.

## Operation
- Output register:
  - A slot is free when `!master_valid_o || master_ready_i`.
  - A beat is accepted from source k when `slave_valid_i[k] && slave_ready_o[k]`.
  - On acceptance the register loads that source's fields and sets master_valid_o.
  - master_valid_o clears only when master_ready_i is high and no beat is accepted.
- FSM states:
  - IDLE (no burst owner): grant is combinational. It goes to the first requesting source at or after rr_ptr in ascending modulo-N order. slave_ready_o[grant] = slot free.
  - LOCKED (owner = lock_idx): slave_ready_o[lock_idx] = slot free; all other readys are 0.
- FSM transitions:
  - IDLE→LOCKED: a beat is accepted with last=0. lock_idx is set to the granted index.
  - IDLE→IDLE: a beat is accepted with last=1 (single-beat burst).
  - LOCKED→IDLE: the owner's beat is accepted with last=1.
  - rr_ptr is set to (burst owner + 1) mod N_SLAVES each time a last beat is accepted.
- Rotation wraps: with owner = N_SLAVES-1, the next rr_ptr is 0.
- A non-owner holding valid while LOCKED waits; its valid and data must stay stable (AXI rule, not checked).
- In IDLE, a source is granted only if its valid is high. No ready is raised when no source is valid.
- The output register and the master_* outputs are pass-through storage; no field is modified.

## Timing
- Reset values: master_valid_o=0; master_data_o, resp, user, id and last all 0; slave_ready_o=0; state=IDLE; rr_ptr=0; lock_idx=0.
- Latency: a beat accepted at edge T is on master_* from T until it is consumed.
- Throughput: 1 beat/cycle under continuous master_ready_i, including back-to-back bursts from different sources. A last beat at edge T allows the next owner's first beat at edge T+1 (no bubble).
- Full register with master_ready_i=0: all slave_ready_o=0. master_* must hold stable.
- Full register with master_ready_i=1 and a granted source valid: consume and load happen in the same edge.
- slave_ready_o depends combinationally on master_ready_i and slave_valid_i. There is no combinational path from master_ready_i to master_*.
- rst_i asserted mid-burst: asynchronous return to the reset values. The beat in flight is dropped and the burst is abandoned.

## Configuration
- PER2AXI_R_ARB_BURST_LOCK_EN defined: burst locking as described above.
- Not defined: LOCKED is never entered and arbitration is per beat.
  - rr_ptr advances to (granted+1) mod N after every accepted beat.
  - Beats of different sources may interleave. This is legal only when the sources use distinct IDs.

## Structure
- Shared package per2axi_pkg: the AXI RESP encodings (OKAY=2'b00, EXOKAY, SLVERR, DECERR) and an r_beat_t struct parameterised by the bridge widths.
- One sub-module: per2axi_rr_pick. It is combinational and takes a request vector and a pointer, returning a one-hot grant plus an index. The FSM and the output register stay in the top.

## Test plan
- Reset: drive rst_i=1 mid-burst, with source 1 owning a 4-beat burst after 2 beats → master_valid_o=0 and all readys 0 immediately. After release, state=IDLE and rr_ptr=0.
- Lock: source 0 sends a 4-beat burst (data 0xA0–0xA3); source 1 is valid from cycle 1 → master sees A0..A3 contiguously, then source 1's beat on the next cycle with no bubble.
- Fairness: N_SLAVES=3, all sources continuously valid with 1-beat bursts → grant order 0,1,2,0,1,2, one beat per cycle.
- Backpressure: master_ready_i=0 for 5 cycles during a burst → master_* stable, slave_ready_o all 0. When ready returns, beats resume in order with none lost or duplicated.
- Wrap: owner = N_SLAVES-1 completes its burst while source 0 and source N_SLAVES-2 request → source 0 is granted next.
- Macro off: sources 0 and 1 each send 2-beat bursts (IDs 1 and 2) simultaneously → master order is 0,1,0,1, with IDs and last flags preserved per beat.
